// File: rtl/digit_step_counter.sv
// digit_step_counter
//   Turns two raw push-buttons into a registered one-hot digit code (0..7)
//   for the downstream one-hot-to-segment encoder. Each button passes
//   through a 2-flop synchroniser, a stability debouncer and a rising-edge
//   detector; a small FSM then steps a 3-bit digit with wrap-around.
//   There is no combinational path from any input to any output.
//
//   Optional feature macro: AUTO_STEP_EN
//     When defined, adds the auto_mode input and a prescaler that steps
//     the digit up every AUTO_DIV cycles while the FSM is idle.
//
// Ports
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   ena           in   1 = run; 0 = freeze debounce, FSM and digit
//   btn_up        in   raw button, 1 = pressed
//   btn_down      in   raw button, 1 = pressed
//   clear         in   synchronous clear of the digit to 0
//   auto_mode     in   (AUTO_STEP_EN only) enable periodic auto-step
//   digit_onehot  out  one-hot digit, bit n set = digit n
//   digit_bin     out  binary digit
//   step_pulse    out  one-cycle strobe after a step or clear
//
// FSM states
//   state     | meaning
//   IDLE      | no button held; accepts a single press (or auto tick)
//   UP_HELD   | up press accepted; waits for debounced up release
//   DOWN_HELD | down press accepted; waits for debounced down release

module digit_step_counter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_DIV        = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       clear,
`ifdef AUTO_STEP_EN
  input  logic       auto_mode,
`endif
  output logic [7:0] digit_onehot,
  output logic [2:0] digit_bin,
  output logic       step_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    UP_HELD   = 2'd1,
    DOWN_HELD = 2'd2
  } state_e;

  // Index 0 = up button, index 1 = down button.
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_prev_q, press_q;
  logic [CW-1:0] cnt_q [2];

  state_e        state_q;
  logic [2:0]    digit_q, digit_d;
  logic [7:0]    onehot_q;
  logic          step_q, step_d;

  logic          up_evt, dn_evt, auto_tc, do_up, do_dn;

  // Synchroniser runs regardless of ena; the debouncer and edge detector
  // freeze with ena so that no press edge is generated or stored meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      deb_q      <= 2'b00;
      deb_prev_q <= 2'b00;
      press_q    <= 2'b00;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= {btn_down, btn_up};
      sync2_q <= sync1_q;
      if (ena) begin
        for (int i = 0; i < 2; i++) begin
          if (sync2_q[i] == deb_q[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == DEB_MAX) begin
            deb_q[i] <= sync2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end
        deb_prev_q <= deb_q;
        press_q    <= deb_q & ~deb_prev_q;
      end else begin
        press_q <= 2'b00;
      end
    end
  end

`ifdef AUTO_STEP_EN
  localparam int PW = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(AUTO_DIV - 1);

  logic [PW-1:0] presc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (ena) begin
      if (!auto_mode || state_q != IDLE || clear || up_evt || dn_evt)
        presc_q <= '0;
      else if (presc_q == PRESC_MAX)
        presc_q <= '0;
      else
        presc_q <= presc_q + 1'b1;
    end
  end
`endif

  always_comb begin
    // Simultaneous presses cancel each other.
    up_evt  = press_q[0] & ~press_q[1];
    dn_evt  = press_q[1] & ~press_q[0];
    auto_tc = 1'b0;
`ifdef AUTO_STEP_EN
    auto_tc = auto_mode & (presc_q == PRESC_MAX);
`endif
    do_up   = (state_q == IDLE) & (up_evt | (auto_tc & ~dn_evt));
    do_dn   = (state_q == IDLE) & dn_evt;

    digit_d = digit_q;
    if (clear)      digit_d = 3'd0;
    else if (do_up) digit_d = digit_q + 3'd1;
    else if (do_dn) digit_d = digit_q - 3'd1;

    step_d  = clear | do_up | do_dn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      digit_q  <= 3'd0;
      onehot_q <= 8'h01;
      step_q   <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (up_evt)      state_q <= UP_HELD;
          else if (dn_evt) state_q <= DOWN_HELD;
        end
        UP_HELD:   if (!deb_q[0]) state_q <= IDLE;
        DOWN_HELD: if (!deb_q[1]) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
      digit_q  <= digit_d;
      onehot_q <= 8'h01 << digit_d;
      step_q   <= step_d;
    end else begin
      step_q <= 1'b0;
    end
  end

  assign digit_onehot = onehot_q;
  assign digit_bin    = digit_q;
  assign step_pulse   = step_q;

endmodule

// File: tb/tb_digit_step_counter.sv
module tb_digit_step_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       clear = 1'b0;
`ifdef AUTO_STEP_EN
  logic       auto_mode = 1'b0;
`endif
  logic [7:0] digit_onehot;
  logic [2:0] digit_bin;
  logic       step_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;

  digit_step_counter #(.DEBOUNCE_CYCLES(4), .AUTO_DIV(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .clear        (clear),
`ifdef AUTO_STEP_EN
    .auto_mode    (auto_mode),
`endif
    .digit_onehot (digit_onehot),
    .digit_bin    (digit_bin),
    .step_pulse   (step_pulse)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (step_pulse === 1'b1) pulse_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Full press of one button: hold for 12 cycles, then release for 10.
  task automatic press(input bit up);
    if (up) btn_up = 1'b1; else btn_down = 1'b1;
    ticks(12);
    btn_up = 1'b0;
    btn_down = 1'b0;
    ticks(10);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ticks(2);
    n_tests++;
    if (digit_onehot !== 8'h01) begin n_fail++; $display("FAIL reset_onehot: got %h want 01", digit_onehot); end
    n_tests++;
    if (digit_bin !== 3'd0) begin n_fail++; $display("FAIL reset_bin: got %0d want 0", digit_bin); end
    n_tests++;
    if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b want 0", step_pulse); end
    rst_n = 1'b1;
    pulse_cnt = 0;
    ticks(20);
    n_tests++;
    if (digit_onehot !== 8'h01 || digit_bin !== 3'd0 || pulse_cnt != 0) begin
      n_fail++;
      $display("FAIL idle_hold: got onehot=%h bin=%0d pulses=%0d want 01/0/0", digit_onehot, digit_bin, pulse_cnt);
    end
  endtask

  task automatic test_first_step();
    pulse_cnt = 0;
    btn_up = 1'b1;
    ticks(7);
    n_tests++;
    if (digit_bin !== 3'd0) begin n_fail++; $display("FAIL latency_early: got %0d want 0 at edge 6", digit_bin); end
    tick();
    n_tests++;
    if (digit_bin !== 3'd1 || digit_onehot !== 8'h02) begin
      n_fail++; $display("FAIL latency_edge7: got bin=%0d onehot=%h want 1/02", digit_bin, digit_onehot);
    end
    n_tests++;
    if (step_pulse !== 1'b1) begin n_fail++; $display("FAIL step_pulse_edge7: got %b want 1", step_pulse); end
    ticks(4);
    btn_up = 1'b0;
    ticks(10);
    n_tests++;
    if (pulse_cnt != 1) begin n_fail++; $display("FAIL one_pulse: got %0d pulses want 1", pulse_cnt); end
  endtask

  task automatic test_wrap_up();
    logic [2:0] exp_seq [8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    for (int i = 0; i < 8; i++) begin
      press(1'b1);
      n_tests++;
      if (digit_bin !== exp_seq[i] || digit_onehot !== (8'h01 << exp_seq[i])) begin
        n_fail++;
        $display("FAIL wrap_up[%0d]: got bin=%0d onehot=%h want %0d", i, digit_bin, digit_onehot, exp_seq[i]);
      end
    end
  endtask

  task automatic test_glitch();
    pulse_cnt = 0;
    btn_up = 1'b1;
    ticks(3);
    btn_up = 1'b0;
    ticks(10);
    n_tests++;
    if (digit_bin !== 3'd1 || pulse_cnt != 0) begin
      n_fail++; $display("FAIL glitch3: got bin=%0d pulses=%0d want 1/0", digit_bin, pulse_cnt);
    end
    btn_up = 1'b1;
    ticks(4);
    btn_up = 1'b0;
    ticks(12);
    n_tests++;
    if (digit_bin !== 3'd2 || pulse_cnt != 1) begin
      n_fail++; $display("FAIL glitch4_steps: got bin=%0d pulses=%0d want 2/1", digit_bin, pulse_cnt);
    end
  endtask

  task automatic test_clear_and_down();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_tests++;
    if (digit_bin !== 3'd0 || digit_onehot !== 8'h01 || step_pulse !== 1'b1) begin
      n_fail++; $display("FAIL clear: got bin=%0d onehot=%h step=%b want 0/01/1", digit_bin, digit_onehot, step_pulse);
    end
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_tests++;
    if (digit_bin !== 3'd0 || step_pulse !== 1'b1) begin
      n_fail++; $display("FAIL clear_at_zero: got bin=%0d step=%b want 0/1", digit_bin, step_pulse);
    end
    press(1'b0);
    n_tests++;
    if (digit_bin !== 3'd7 || digit_onehot !== 8'h80) begin
      n_fail++; $display("FAIL down_wrap: got bin=%0d onehot=%h want 7/80", digit_bin, digit_onehot);
    end
    press(1'b1);
    press(1'b1);
    n_tests++;
    if (digit_bin !== 3'd1) begin n_fail++; $display("FAIL up_after_down: got %0d want 1", digit_bin); end
  endtask

  task automatic test_clear_in_step();
    pulse_cnt = 0;
    btn_up = 1'b1;
    ticks(7);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_tests++;
    if (digit_bin !== 3'd0 || step_pulse !== 1'b1) begin
      n_fail++; $display("FAIL clear_over_step: got bin=%0d step=%b want 0/1", digit_bin, step_pulse);
    end
    // Up is still held, so a down press now must be ignored.
    btn_down = 1'b1;
    ticks(12);
    btn_up = 1'b0;
    btn_down = 1'b0;
    ticks(12);
    n_tests++;
    if (digit_bin !== 3'd0 || pulse_cnt != 1) begin
      n_fail++; $display("FAIL down_in_up_held: got bin=%0d pulses=%0d want 0/1", digit_bin, pulse_cnt);
    end
  endtask

  task automatic test_simultaneous();
    pulse_cnt = 0;
    btn_up = 1'b1;
    btn_down = 1'b1;
    ticks(12);
    btn_up = 1'b0;
    btn_down = 1'b0;
    ticks(12);
    n_tests++;
    if (digit_bin !== 3'd0 || pulse_cnt != 0) begin
      n_fail++; $display("FAIL simultaneous: got bin=%0d pulses=%0d want 0/0", digit_bin, pulse_cnt);
    end
  endtask

  task automatic test_ena();
    pulse_cnt = 0;
    ena = 1'b0;
    press(1'b1);
    ena = 1'b1;
    ticks(10);
    n_tests++;
    if (digit_bin !== 3'd0 || pulse_cnt != 0) begin
      n_fail++; $display("FAIL ena_freeze: got bin=%0d pulses=%0d want 0/0", digit_bin, pulse_cnt);
    end
    press(1'b1);
    n_tests++;
    if (digit_bin !== 3'd1) begin n_fail++; $display("FAIL ena_resume: got %0d want 1", digit_bin); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) press(1'b1);
    btn_up = 1'b1;
    ticks(4);
    n_tests++;
    if (digit_bin !== 3'd5) begin n_fail++; $display("FAIL pre_reset: got %0d want 5", digit_bin); end
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (digit_onehot !== 8'h01 || digit_bin !== 3'd0 || step_pulse !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got onehot=%h bin=%0d step=%b want 01/0/0", digit_onehot, digit_bin, step_pulse);
    end
    ticks(2);
    rst_n = 1'b1;
    pulse_cnt = 0;
    ticks(14);
    n_tests++;
    if (digit_bin !== 3'd1 || digit_onehot !== 8'h02 || pulse_cnt != 1) begin
      n_fail++; $display("FAIL held_through_reset: got bin=%0d onehot=%h pulses=%0d want 1/02/1", digit_bin, digit_onehot, pulse_cnt);
    end
    btn_up = 1'b0;
    ticks(10);
  endtask

`ifdef AUTO_STEP_EN
  task automatic test_auto();
    logic [2:0] exp_seq [8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    auto_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ticks(4);
      n_tests++;
      if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL auto_early[%0d]: step=%b want 0", i, step_pulse); end
      tick();
      n_tests++;
      if (digit_bin !== exp_seq[i] || step_pulse !== 1'b1) begin
        n_fail++; $display("FAIL auto_step[%0d]: got bin=%0d step=%b want %0d/1", i, digit_bin, step_pulse, exp_seq[i]);
      end
    end
    ticks(2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    ticks(4);
    n_tests++;
    if (digit_bin !== 3'd0) begin n_fail++; $display("FAIL auto_restart_early: got %0d want 0", digit_bin); end
    tick();
    n_tests++;
    if (digit_bin !== 3'd1) begin n_fail++; $display("FAIL auto_restart: got %0d want 1", digit_bin); end
    auto_mode = 1'b0;
    ticks(2);
  endtask
`endif

  initial begin
    test_reset();
    test_first_step();
    test_wrap_up();
    test_glitch();
    test_clear_and_down();
    test_clear_in_step();
    test_simultaneous();
    test_ena();
    test_async_reset();
`ifdef AUTO_STEP_EN
    test_auto();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
